// File: rtl/ds1302_ctrl_pkg.sv
// Shared types and helpers for the DS1302 three-wire transaction engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ds1302_ctrl_pkg;

    // Transaction phases, in the order a transaction walks through them.
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        CMD,
        WDATA,
        RDATA,
        HOLD,
        RECOVER,
        DONE
    } state_e;

    // The mode value equals the R/W bit that ends up in command bit 0.
    typedef enum logic {
        MODE_WRITE = 1'b0,
        MODE_READ  = 1'b1
    } mode_e;

    // Half-period of the DS1302 serial clock, in system clocks.
    function automatic int calc_div(input int f_sys, input int f_ser);
        return f_sys / (2 * f_ser);
    endfunction

endpackage

// File: rtl/ds1302_ctrl_half_tick.sv
// Free-running divider: one-cycle tick every DIV system clocks, restartable.
// Latency: first tick DIV cycles after the last cycle clr_i was high.
// Backpressure: none; the tick is a pure timebase.
module ds1302_half_tick #(
    parameter int DIV = 50
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign tick_o = (cnt_q == CW'(DIV - 1));

    // Count 0..DIV-1, wrapping on the tick; clr_i restarts the phase.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/ds1302_ctrl.sv
// DS1302 single-byte read/write engine driving CE, SCLK and bidirectional I/O.
// Latency: done pulse 38*DIV cycles after the trigger edge; CE high for 36*DIV.
// Backpressure: triggers are only sampled in IDLE; triggers while busy are dropped.
module ds1302_ctrl
    import ds1302_ctrl_pkg::*;
#(
    parameter int sclk_freq        = 50_000_000,
    parameter int ds1302_clk_speed = 500_000
) (
    input  logic       sclk,
    input  logic       nrst,
    input  logic [7:0] addr,
    input  logic [7:0] write_byte,
    output logic [7:0] read_byte,
    input  logic       write_trigger,
    input  logic       read_trigger,
    output logic       write_done,
    output logic       read_done,
    output logic       ds1302_ce,
    output logic       ds1302_sclk,
    inout  wire        ds1302_io
);

    localparam int DIV = calc_div(sclk_freq, ds1302_clk_speed);

    state_e     state_q;
    mode_e      mode_q;
    logic [7:0] shift_q;     // bit 0 is what I/O drives
    logic [7:0] data_q;      // write data, loaded into shift_q after the command
    logic [7:0] rx_q;        // read bits shift in from the top, LSB first
    logic [7:0] read_byte_q;
    logic       half_q;      // 0: low half of a bit period, 1: high half
    logic [2:0] bit_q;
    logic       ce_q;
    logic       sclk_q;
    logic       oe_q;
    logic       wdone_q;
    logic       rdone_q;
    logic       tick;

    // Restart the timebase while idle so the first half-period is exactly DIV.
    ds1302_half_tick #(
        .DIV(DIV)
    ) u_half_tick (
        .clk_i (sclk),
        .rst_ni(nrst),
        .clr_i (state_q == IDLE),
        .tick_o(tick)
    );

    assign ds1302_io   = oe_q ? shift_q[0] : 1'bz;
    assign ds1302_ce   = ce_q;
    assign ds1302_sclk = sclk_q;
    assign read_byte   = read_byte_q;
    assign write_done  = wdone_q;
    assign read_done   = rdone_q;

    // Transaction sequencer; every pin and status output is a register.
    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            mode_q      <= MODE_WRITE;
            shift_q     <= '0;
            data_q      <= '0;
            rx_q        <= '0;
            read_byte_q <= '0;
            half_q      <= 1'b0;
            bit_q       <= '0;
            ce_q        <= 1'b0;
            sclk_q      <= 1'b0;
            oe_q        <= 1'b0;
            wdone_q     <= 1'b0;
            rdone_q     <= 1'b0;
        end else begin
            wdone_q <= 1'b0;
            rdone_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    half_q <= 1'b0;
                    bit_q  <= '0;
                    if (write_trigger) begin
                        shift_q <= addr & 8'hFE;
                        data_q  <= write_byte;
                        mode_q  <= MODE_WRITE;
                        ce_q    <= 1'b1;
                        oe_q    <= 1'b1;
                        state_q <= SETUP;
                    end else if (read_trigger) begin
                        shift_q <= addr | 8'h01;
                        mode_q  <= MODE_READ;
                        ce_q    <= 1'b1;
                        oe_q    <= 1'b1;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        half_q <= ~half_q;
                        if (half_q) state_q <= CMD;
                    end
                end
                CMD, WDATA, RDATA: begin
                    if (tick) begin
                        if (!half_q) begin
                            // Rising SCLK; read bits are taken just before it.
                            half_q <= 1'b1;
                            sclk_q <= 1'b1;
                            if (state_q == RDATA) rx_q <= {ds1302_io, rx_q[7:1]};
                        end else begin
                            // Falling SCLK presents the next bit.
                            half_q  <= 1'b0;
                            sclk_q  <= 1'b0;
                            shift_q <= {1'b0, shift_q[7:1]};
                            if (bit_q == 3'd7) begin
                                bit_q <= '0;
                                if (state_q == CMD) begin
                                    if (mode_q == MODE_WRITE) begin
                                        shift_q <= data_q;
                                        state_q <= WDATA;
                                    end else begin
                                        oe_q    <= 1'b0;
                                        state_q <= RDATA;
                                    end
                                end else begin
                                    oe_q    <= 1'b0;
                                    state_q <= HOLD;
                                end
                            end else begin
                                bit_q <= bit_q + 3'd1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        half_q <= ~half_q;
                        if (half_q) begin
                            ce_q    <= 1'b0;
                            state_q <= RECOVER;
                        end
                    end
                end
                RECOVER: begin
                    if (tick) begin
                        half_q <= ~half_q;
                        if (half_q) begin
                            state_q <= DONE;
                            if (mode_q == MODE_WRITE) begin
                                wdone_q <= 1'b1;
                            end else begin
                                rdone_q     <= 1'b1;
                                read_byte_q <= rx_q;
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ds1302_ctrl.sv
// Directed bench for ds1302_ctrl with a behavioural DS1302 on the I/O line.
// Latency: n/a.
// Backpressure: n/a.
module tb_ds1302_ctrl;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wbyte = 8'h00;
    logic       wt0 = 1'b0, rt0 = 1'b0, wt1 = 1'b0, rt1 = 1'b0;
    logic       sel = 1'b0;

    wire [7:0] rb0, rb1;
    wire       wd0, rd0, wd1, rd1, ce0, ce1, sc0, sc1;
    wire       io0, io1;

    // Behavioural DS1302 output driver; the line idles low when nobody drives.
    logic       mdl_en = 1'b0;
    logic       mdl_oe;
    logic       mdl_out;
    logic [7:0] mdl_byte = 8'h00;

    pulldown (io0);
    pulldown (io1);
    assign io0 = mdl_oe ? mdl_out : 1'bz;

    ds1302_ctrl dut0 (
        .sclk(clk), .nrst(nrst), .addr(addr), .write_byte(wbyte), .read_byte(rb0),
        .write_trigger(wt0), .read_trigger(rt0), .write_done(wd0), .read_done(rd0),
        .ds1302_ce(ce0), .ds1302_sclk(sc0), .ds1302_io(io0)
    );

    ds1302_ctrl #(.ds1302_clk_speed(1_000_000)) dut1 (
        .sclk(clk), .nrst(nrst), .addr(addr), .write_byte(wbyte), .read_byte(rb1),
        .write_trigger(wt1), .read_trigger(rt1), .write_done(wd1), .read_done(rd1),
        .ds1302_ce(ce1), .ds1302_sclk(sc1), .ds1302_io(io1)
    );

    wire       obs_ce   = sel ? ce1 : ce0;
    wire       obs_sclk = sel ? sc1 : sc0;
    wire       obs_io   = sel ? io1 : io0;
    wire       obs_wd   = sel ? wd1 : wd0;
    wire       obs_rd   = sel ? rd1 : rd0;
    wire [7:0] obs_rb   = sel ? rb1 : rb0;

    always #5 clk = ~clk;

    // DS1302 model: drives read data 100 ns after each SCLK fall following the command.
    initial begin
        mdl_oe  = 1'b0;
        mdl_out = 1'b0;
        forever begin
            @(posedge ce0);
            for (int k = 1; k <= 16; k++) begin
                @(negedge sc0 or negedge ce0);
                if (!ce0) break;
                if (mdl_en && k >= 8 && k < 16) begin
                    #100;
                    mdl_oe  = 1'b1;
                    mdl_out = mdl_byte[k-8];
                end else if (k == 16) begin
                    #100;
                    mdl_oe = 1'b0;
                end
            end
            mdl_oe = 1'b0;
        end
    end

    int checks = 0;
    int errors = 0;

    // Per-transaction observations, all indexed by cycles after the trigger edge.
    logic [15:0] cap;
    int          nrise, ce_cyc, wd_cnt, rd_cnt, wd_time, rd_time, first_rise, first_fall;
    logic [7:0]  rb_done;
    logic        rel_io, hold_io, rst_ce, rst_sclk, rst_io;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic w, input logic r);
        if (sel) begin wt1 = w; rt1 = r; end
        else     begin wt0 = w; rt0 = r; end
        @(negedge clk);
        wt0 = 1'b0; rt0 = 1'b0; wt1 = 1'b0; rt1 = 1'b0;
    endtask

    // Observe ncyc cycles; optionally inject a read trigger or a reset at a given cycle.
    task automatic run_txn(input int ncyc, input int inj_cyc, input int rst_cyc);
        logic prev = 1'b0;
        cap = '0; nrise = 0; ce_cyc = 0; wd_cnt = 0; rd_cnt = 0;
        wd_time = -1; rd_time = -1; first_rise = -1; first_fall = -1;
        rb_done = 8'h00; rel_io = 1'bx; hold_io = 1'bx;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            if (cyc == inj_cyc) rt0 = 1'b1;
            else if (cyc == inj_cyc + 1) rt0 = 1'b0;
            if (cyc == rst_cyc) begin
                nrst = 1'b0;
                #1;
                rst_ce = obs_ce; rst_sclk = obs_sclk; rst_io = obs_io;
            end
            if (cyc == rst_cyc + 3) nrst = 1'b1;
            if (obs_ce) ce_cyc++;
            if (obs_sclk && !prev) begin
                if (nrise < 16) cap[nrise] = obs_io;
                nrise++;
                if (first_rise < 0) first_rise = cyc;
            end
            if (!obs_sclk && prev && first_fall < 0) first_fall = cyc;
            prev = obs_sclk;
            if (obs_wd) begin wd_cnt++; wd_time = cyc; end
            if (obs_rd) begin rd_cnt++; rd_time = cyc; rb_done = obs_rb; end
            if (cyc == 905)  rel_io  = obs_io;
            if (cyc == 1750) hold_io = obs_io;
            @(negedge clk);
        end
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ce", ce0, 1'b0);
        check("rst_sclk", sc0, 1'b0);
        check("rst_io_z", io0, 1'b0);
        check("rst_read_byte", rb0, 8'h00);
        check("rst_write_done", wd0, 1'b0);
        check("rst_read_done", rd0, 1'b0);
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        // Write 0x82 <- 0xB5
        addr = 8'h82; wbyte = 8'hB5;
        start(1'b1, 1'b0);
        run_txn(2100, -10, -10);
        check("wr_bits", cap, 16'hB582);
        check("wr_nrise", nrise, 16);
        check("wr_ce_cycles", ce_cyc, 1800);
        check("wr_done_count", wd_cnt, 1);
        check("wr_done_time", wd_time, 1900);
        check("wr_no_read_done", rd_cnt, 0);
        check("wr_hold_io_z", hold_io, 1'b0);
        check("wr_sclk_rise", first_rise, 150);
        check("wr_sclk_high", first_fall - first_rise, 50);

        // Read 0x82 (command 0x83), DS1302 returns 0x5A
        addr = 8'h82; mdl_byte = 8'h5A; mdl_en = 1'b1;
        start(1'b0, 1'b1);
        run_txn(2100, -10, -10);
        mdl_en = 1'b0;
        check("rd_bits", cap, 16'h5A83);
        check("rd_io_released", rel_io, 1'b0);
        check("rd_done_count", rd_cnt, 1);
        check("rd_done_time", rd_time, 1900);
        check("rd_no_write_done", wd_cnt, 0);
        check("rd_byte_at_done", rb_done, 8'h5A);
        check("rd_byte_hold", rb0, 8'h5A);
        check("rd_ce_cycles", ce_cyc, 1800);

        // Both triggers together: write wins, bit0 forced to 0
        addr = 8'h8D; wbyte = 8'h3C;
        start(1'b1, 1'b1);
        run_txn(2100, -10, -10);
        check("both_bits", cap, 16'h3C8C);
        check("both_write_done", wd_cnt, 1);
        check("both_no_read_done", rd_cnt, 0);
        check("both_read_byte_kept", rb0, 8'h5A);

        // Read trigger 500 cycles into a write is dropped
        addr = 8'h80; wbyte = 8'h11;
        start(1'b1, 1'b0);
        run_txn(2100, 500, -10);
        check("busy_write_done", wd_cnt, 1);
        check("busy_no_read_done", rd_cnt, 0);
        check("busy_ce_cycles", ce_cyc, 1800);

        // Reset during command bit 3 (0x8E has bit 3 set)
        addr = 8'h8E; wbyte = 8'h00;
        start(1'b1, 1'b0);
        run_txn(2100, -10, 420);
        check("abort_ce", rst_ce, 1'b0);
        check("abort_sclk", rst_sclk, 1'b0);
        check("abort_io_z", rst_io, 1'b0);
        check("abort_no_write_done", wd_cnt, 0);
        check("abort_no_read_done", rd_cnt, 0);
        check("abort_ce_cycles", ce_cyc, 420);

        // Normal write after the aborted one
        addr = 8'h82; wbyte = 8'hB5;
        start(1'b1, 1'b0);
        run_txn(2100, -10, -10);
        check("post_bits", cap, 16'hB582);
        check("post_done_count", wd_cnt, 1);
        check("post_done_time", wd_time, 1900);

        // 1 MHz SCLK instance: half-period 25, done after 950
        sel = 1'b1;
        addr = 8'hC0; wbyte = 8'hA5;
        start(1'b1, 1'b0);
        run_txn(1200, -10, -10);
        check("fast_bits", cap, 16'hA5C0);
        check("fast_sclk_high", first_fall - first_rise, 25);
        check("fast_done_time", wd_time, 950);
        check("fast_ce_cycles", ce_cyc, 900);
        check("fast_done_count", wd_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ds1302_ctrl.md
Name: ds1302_ctrl

Overview:
- Single-byte serial transaction engine for the DS1302 RTC three-wire interface (CE, SCLK, bidirectional I/O).
- On a write trigger it shifts out one command byte and one data byte, LSB first.
- On a read trigger it shifts out the command byte, then releases I/O and captures one data byte.
- Sits between the time-keeping/display logic and the DS1302 pins; upper logic sequences register accesses by pulsing triggers and waiting for done pulses.

Parameters:
- sclk_freq, 50_000_000: system clock frequency in Hz.
- ds1302_clk_speed, 500_000: DS1302 SCLK frequency in Hz.
- Derived constant DIV = sclk_freq/(2*ds1302_clk_speed), the half-period in system clocks (50 at defaults). DIV must be ≥ 2.

Ports:
- sclk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- addr  in  8  DS1302 command byte; bit0 is overridden (write forces 0, read forces 1).
- write_byte  in  8  data to write.
- read_byte  out  8  last captured read data.
- write_trigger  in  1  one-cycle start of write transaction.
- read_trigger  in  1  one-cycle start of read transaction.
- write_done  out  1  one-cycle pulse at write completion.
- read_done  out  1  one-cycle pulse at read completion; read_byte is valid from this cycle.
- ds1302_ce  out  1  chip enable.
- ds1302_sclk  out  1  serial clock.
- ds1302_io  inout  1  serial data; high-Z whenever not driven.

Behaviour:
- Reset (nrst=0, asynchronous): state IDLE, all counters 0, ds1302_ce=0, ds1302_sclk=0, io high-Z, read_byte=0x00, write_done=0, read_done=0. Reset mid-transaction aborts immediately with these values.
- IDLE: triggers are sampled only here.
  - If write_trigger=1 (write has priority when both are high), latch {addr[7:1],0} and write_byte, set mode=write.
  - Else if read_trigger=1, latch {addr[7:1],1}, set mode=read.
  - On the same edge, set ce←1 and go to SETUP.
  - Triggers are ignored while busy (no queueing).
- SETUP: 2*DIV cycles with ce=1, sclk=0; io drives command bit0.
- CMD: 8 bits, LSB first, each bit 2*DIV cycles.
  - Low half (DIV cycles): sclk=0, io drives the bit.
  - High half (DIV cycles): sclk=1; DS1302 samples on the rising edge.
  - The next bit is presented when sclk falls.
- WDATA (write mode): identical to CMD, using the latched data byte.
- RDATA (read mode):
  - io goes high-Z on the edge where the 8th command bit's sclk falls.
  - Then 8 bit periods of 2*DIV cycles: low half DIV cycles, high half DIV cycles.
  - Data bit i (LSB first) is sampled from io on the last system clock of the low half, just before the rising edge.
- HOLD: 2*DIV cycles, ce=1, sclk=0, io high-Z. Then ce←0.
- RECOVER: 2*DIV cycles with ce=0, then the done pulse for the current mode.
  - read_byte updates on the same edge read_done rises, then holds until the next read completes.
  - Return to IDLE; a trigger in the cycle after done is accepted.
- Timing: ce is high for exactly 36*DIV cycles. The done pulse rises exactly 38*DIV cycles after the trigger-sampling edge (1900 cycles = 38 µs at defaults).
- io is driven only in SETUP, CMD, WDATA; it is high-Z in every other state.
- sclk is 0 in IDLE, SETUP, HOLD, RECOVER.

Decomposition:
- Shared package: state enum (IDLE, SETUP, CMD, WDATA, RDATA, HOLD, RECOVER, DONE), mode encoding, DIV computation function.
- One natural sub-module, ds1302_half_tick: a counter producing a one-cycle tick every DIV cycles, cleared on transaction start.
- The FSM, shift register, and tri-state buffer stay in the top module.

Test Plan:
- Write: addr=0x82, write_byte=0xB5, one write_trigger pulse.
  - Sampling io on sclk rising edges gives bits 0,1,0,0,0,0,0,1 then 1,0,1,0,1,1,0,1.
  - ce high for 1800 cycles; write_done single pulse 1900 cycles after the trigger.
- Read: addr=0x82 with a DS1302 model driving 0x5A on falling edges.
  - Command shifted is 0x83; io is released after the 8th command bit's sclk falls.
  - read_done pulses with read_byte=0x5A, and read_byte holds afterwards.
- Simultaneous write_trigger and read_trigger in one cycle: write executes, no read occurs, only write_done pulses.
- Trigger while busy: read_trigger pulsed 500 cycles into a write is ignored; exactly one write_done and no read_done.
- Reset mid-transaction: nrst low during CMD bit 3 gives ce=0, sclk=0, io high-Z, no done pulse. After release, a new write completes normally.
- Parameter check: ds1302_clk_speed=1_000_000 gives a sclk half-period of 25 cycles and a done pulse 950 cycles after the trigger.
